// File: rtl/core_seq_pkg.sv
// Shared types and constants for the convolution-pass sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_WGAP  = 3'd2,
    S_XFEED = 3'd3,
    S_DRAIN = 3'd4,
    S_RELU  = 3'd5,
    S_ROUT  = 3'd6,
    S_DONE  = 3'd7
  } seq_state_e;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_WLOAD = 2'b01;
  localparam logic [1:0] INST_XFEED = 2'b10;

  function automatic logic [1:0] inst_of(seq_state_e s);
    case (s)
      S_WLOAD: return INST_WLOAD;
      S_XFEED: return INST_XFEED;
      default: return INST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Host/core-facing signal bundle of the sequencer.
interface core_seq_ctrl_if #(parameter int addr_bw = 11);
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic [1:0]         inst_w;
  logic               CEN_xmem;
  logic               WEN_xmem;
  logic [addr_bw-1:0] A_xmem;
  logic [3:0]         kij;
  logic               readout_start;

  modport master (
    input  start, stall,
    output busy, done, inst_w, CEN_xmem, WEN_xmem, A_xmem, kij, readout_start
  );

  modport slave (
    output start, stall,
    input  busy, done, inst_w, CEN_xmem, WEN_xmem, A_xmem, kij, readout_start
  );
endinterface

// File: rtl/core_seq_ctrl_phase_cnt.sv
// Loadable down-counter timing each sequencer phase; tc flags the last cycle.
module seq_phase_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load)             cnt <= load_val;
      else if (clr)         cnt <= '0;
      else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/core_seq_ctrl.sv
// Walks every kernel position of one convolution pass: weight load, activation
// feed, drain, then ReLU settle and readout, with all outputs registered.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int col          = 8,
  parameter int len_nij      = 36,
  parameter int len_kij      = 9,
  parameter int drain_cycles = 30,
  parameter int relu_cycles  = 20,
  parameter int addr_bw      = 11,
  parameter int x_base       = 0,
  parameter int w_base       = 1024
) (
  input  logic            clk,
  input  logic            reset,
  core_seq_ctrl_if.master bus
);

  localparam int MAX_AB  = (col > len_nij) ? col : len_nij;
  localparam int MAX_CD  = (drain_cycles > relu_cycles) ? drain_cycles : relu_cycles;
  localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  seq_state_e         state, nxt;
  logic [3:0]         kij_q, kij_nxt;
  logic [CNT_W-1:0]   cnt, ld_val;
  logic               ld, tc, frozen;
  logic [addr_bw-1:0] a_q, a_nxt;
  logic [1:0]         inst_q;
  logic               cen_q, busy_q, done_q, rs_q;
  int                 t_nxt;

  // A stalled cycle re-presents the pending position with the memory disabled.
  assign frozen = bus.stall && (state != S_IDLE);

  seq_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr      (state == S_IDLE),
    .en       (!bus.stall),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  always_comb begin
    nxt     = state;
    kij_nxt = kij_q;
    ld      = 1'b0;
    ld_val  = '0;
    case (state)
      S_IDLE:  if (bus.start && !bus.stall) begin
                 nxt = S_WLOAD; ld = 1'b1; ld_val = CNT_W'(col - 1); kij_nxt = 4'd0;
               end
      S_WLOAD: if (tc) begin nxt = S_WGAP; ld = 1'b1; end
      S_WGAP:  begin nxt = S_XFEED; ld = 1'b1; ld_val = CNT_W'(len_nij - 1); end
      S_XFEED: if (tc) begin nxt = S_DRAIN; ld = 1'b1; ld_val = CNT_W'(drain_cycles - 1); end
      S_DRAIN: if (tc) begin
                 ld = 1'b1;
                 if (kij_q < 4'(len_kij - 1)) begin
                   nxt = S_WLOAD; ld_val = CNT_W'(col - 1); kij_nxt = kij_q + 4'd1;
                 end else begin
                   nxt = S_RELU; ld_val = CNT_W'(relu_cycles - 1);
                 end
               end
      S_RELU:  if (tc) begin nxt = S_ROUT; ld = 1'b1; end
      S_ROUT:  begin nxt = S_DONE; ld = 1'b1; end
      S_DONE:  begin nxt = S_IDLE; kij_nxt = 4'd0; ld = 1'b1; end
      default: nxt = S_IDLE;
    endcase
  end

  // Address derives from phase position only, so repeated stall edges leave it stable.
  always_comb begin
    t_nxt = 0;
    a_nxt = a_q;
    case (nxt)
      S_WLOAD: begin
        if (state == S_WLOAD) t_nxt = col - int'(cnt);
        a_nxt = addr_bw'(w_base + int'(kij_nxt) * col + t_nxt);
      end
      S_XFEED: begin
        if (state == S_XFEED) t_nxt = len_nij - int'(cnt);
        a_nxt = addr_bw'(x_base + t_nxt);
      end
      default: a_nxt = a_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      kij_q  <= 4'd0;
      inst_q <= INST_IDLE;
      cen_q  <= 1'b1;
      a_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rs_q   <= 1'b0;
    end else if (frozen) begin
      inst_q <= INST_IDLE;
      cen_q  <= 1'b1;
      a_q    <= a_nxt;
      done_q <= 1'b0;
      rs_q   <= 1'b0;
    end else begin
      state  <= nxt;
      kij_q  <= kij_nxt;
      inst_q <= inst_of(nxt);
      cen_q  <= (inst_of(nxt) == INST_IDLE);
      a_q    <= a_nxt;
      busy_q <= (nxt != S_IDLE);
      done_q <= (nxt == S_DONE);
      rs_q   <= (nxt == S_ROUT);
    end
  end

  assign bus.inst_w        = inst_q;
  assign bus.CEN_xmem      = cen_q;
  assign bus.WEN_xmem      = 1'b1;
  assign bus.A_xmem        = a_q;
  assign bus.kij           = kij_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.readout_start = rs_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: full passes with and without stall, reset abort.
module tb_core_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_seq_ctrl_if #(.addr_bw(11)) bus ();

  core_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] inst;
    int         a;
    int         kij;
    logic       busy;
    logic       done;
    logic       rs;
    bit         chk_a;
    bit         chk_kij;
  } vec_t;

  vec_t vecs [16];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " inst_w"}, bus.inst_w, 0);
    check({tag, " CEN"}, bus.CEN_xmem, 1);
    check({tag, " WEN"}, bus.WEN_xmem, 1);
    check({tag, " A"}, bus.A_xmem, 0);
    check({tag, " kij"}, bus.kij, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " done"}, bus.done, 0);
    check({tag, " readout"}, bus.readout_start, 0);
  endtask

  // Start pulse sampled at edge E0; returns just after E0.
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_pass(input bit do_stall, input bit poke_start);
    int sh, wen_bad, cen_bad, wr, ar, kij_bad;
    sh = do_stall ? 5 : 0;
    wen_bad = 0; cen_bad = 0; wr = 0; ar = 0; kij_bad = 0;
    do_start();
    for (int c = 1; c <= 706; c++) begin
      @(negedge clk);
      if (bus.WEN_xmem !== 1'b1) wen_bad++;
      if ((bus.CEN_xmem === 1'b0) != (bus.inst_w !== 2'b00)) cen_bad++;
      if (bus.CEN_xmem === 1'b0 && bus.inst_w === 2'b01) wr++;
      if (bus.CEN_xmem === 1'b0 && bus.inst_w === 2'b10) ar++;
      if (c >= 226 + sh && c <= 300 + sh && bus.kij !== 4'd3) kij_bad++;
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].cyc + ((vecs[i].cyc > 19) ? sh : 0) == c) begin
          check($sformatf("c%0d inst_w", c), bus.inst_w, vecs[i].inst);
          check($sformatf("c%0d busy", c), bus.busy, vecs[i].busy);
          check($sformatf("c%0d done", c), bus.done, vecs[i].done);
          check($sformatf("c%0d readout", c), bus.readout_start, vecs[i].rs);
          if (vecs[i].chk_a)   check($sformatf("c%0d A", c), bus.A_xmem, vecs[i].a);
          if (vecs[i].chk_kij) check($sformatf("c%0d kij", c), bus.kij, vecs[i].kij);
        end
      end
      if (do_stall) begin
        if (c >= 20 && c <= 24) begin
          check($sformatf("stall c%0d inst_w", c), bus.inst_w, 0);
          check($sformatf("stall c%0d CEN", c), bus.CEN_xmem, 1);
          check($sformatf("stall c%0d A", c), bus.A_xmem, 10);
        end
        if (c == 25) begin
          check("resume inst_w", bus.inst_w, 2);
          check("resume CEN", bus.CEN_xmem, 0);
          check("resume A", bus.A_xmem, 10);
        end
        if (c == 26) check("resume+1 A", bus.A_xmem, 11);
        if (c == 701) check("stall readout", bus.readout_start, 1);
        if (c == 702) check("stall done", bus.done, 1);
      end
      bus.stall = do_stall && (c >= 19 && c < 24);
      bus.start = poke_start && (c == 300);
    end
    check("WEN never low", wen_bad, 0);
    check("CEN vs inst_w", cen_bad, 0);
    check("weight reads", wr, 72);
    check("activation reads", ar, 324);
    check("kij3 held", kij_bad, 0);
  endtask

  initial begin
    vecs[0]  = '{1,   2'b01, 1024, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2,   2'b01, 1025, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{8,   2'b01, 1031, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{9,   2'b00, 0,    0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{10,  2'b10, 0,    0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{45,  2'b10, 35,   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{46,  2'b00, 0,    0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{76,  2'b01, 1032, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{226, 2'b01, 1048, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{233, 2'b01, 1055, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{301, 2'b01, 1056, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{675, 2'b00, 0,    8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{695, 2'b00, 0,    0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{696, 2'b00, 0,    0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{697, 2'b00, 0,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{698, 2'b00, 0,    0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Full pass; start poked at cycle 300 must be ignored.
    run_pass(1'b0, 1'b1);

    // start with stall high in IDLE is dropped, not latched.
    @(negedge clk);
    bus.start = 1'b1;
    bus.stall = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("idle stall busy", bus.busy, 0);
    check("idle stall inst_w", bus.inst_w, 0);
    repeat (3) @(negedge clk);
    check("idle stall busy later", bus.busy, 0);

    // Full pass with a 5-cycle stall from XFEED t=10.
    run_pass(1'b1, 1'b0);

    // Reset in cycle 400 mid-XFEED, then a fresh pass.
    do_start();
    for (int c = 1; c <= 400; c++) @(negedge clk);
    check("pre-reset inst_w", bus.inst_w, 2);
    check("pre-reset kij", bus.kij, 5);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    do_start();
    @(negedge clk);
    check("replay inst_w", bus.inst_w, 1);
    check("replay A", bus.A_xmem, 1024);
    check("replay kij", bus.kij, 0);
    @(negedge clk);
    check("replay A+1", bus.A_xmem, 1025);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

On-chip sequencer that replaces bench-driven stimulus for one full convolution pass on `core`. After one `start` pulse it walks all kernel positions kij = 0..len_kij-1. For each kij it streams `col` weight rows from X_MEM into the L0 FIFO, streams `len_nij` activation rows, then waits a fixed drain interval. After the last kij it waits for ReLU to settle and issues `readout_start`. It sits between the host/top level and `core`, and drives `core`'s inst_w, X_MEM control and kij ports.

## Interface
Parameters:
- col, 8, weight rows per kij (array columns)
- len_nij, 36, activation rows per kij
- len_kij, 9, kernel positions per pass
- drain_cycles, 30, idle cycles after each activation feed
- relu_cycles, 20, idle cycles after last kij before readout
- addr_bw, 11, X_MEM address width
- x_base, 0, activation base address
- w_base, 1024, weight base address; kij k's weights live at w_base + k*col

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous active-high reset
- start  in  1  begin a pass; sampled only in IDLE with stall=0
- stall  in  1  freeze sequencing while high
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end
- inst_w  out  2  to core: 00 idle, 01 weight load, 10 activation feed
- CEN_xmem  out  1  X_MEM chip enable, active-low
- WEN_xmem  out  1  X_MEM write enable; tied to 1 (read-only master)
- A_xmem  out  addr_bw  X_MEM read address
- kij  out  4  current kernel index, to SFU
- readout_start  out  1  one-cycle pulse to core

## Operation
- All outputs are registered Moore outputs.
- Reset values: inst_w=00, CEN_xmem=1, WEN_xmem=1, A_xmem=0, kij=0, busy=0, done=0, readout_start=0. The state returns to IDLE.
- States:
  - IDLE: wait for start.
  - WLOAD: col cycles; inst_w=01, CEN=0, A=w_base+kij*col+t.
  - WGAP: 1 cycle; inst_w=00, CEN=1.
  - XFEED: len_nij cycles; inst_w=10, CEN=0, A=x_base+t.
  - DRAIN: drain_cycles cycles; inst_w=00, CEN=1.
  - Exit from DRAIN: if kij<len_kij-1, increment kij and go to WLOAD; otherwise go to RELU.
  - RELU: relu_cycles cycles.
  - ROUT: 1 cycle; readout_start=1.
  - DONE: 1 cycle; done=1. Then back to IDLE with kij=0.
- t is a phase counter that clears on every state entry.
- Address arithmetic is modulo 2^addr_bw.
- kij holds its value through WLOAD..DRAIN of its iteration.
- stall=1 in any non-IDLE state:
  - state and counters freeze;
  - outputs are forced to inst_w=00, CEN=1;
  - A_xmem and kij hold.
  - On release the sequence resumes at the same t. No row is skipped or repeated.
- start while busy is ignored. start with stall=1 in IDLE is ignored (not latched).
- Asserting reset mid-pass immediately forces the reset values. No partial output pulse may occur.

## Timing
- start accepted at clock edge E0. Cycle 1 (after E0) is the first WLOAD cycle, with busy=1.
- Per-kij length: col+1+len_nij+drain_cycles = 75 cycles at defaults.
- Defaults, no stall:
  - cycles 1..675 are the kij phases;
  - cycles 676..695 are RELU;
  - readout_start=1 in cycle 696;
  - done=1 and busy=1 in cycle 697;
  - busy=0 from cycle 698.
- Each stalled cycle adds exactly one cycle to all subsequent event times.
- A new start is accepted at the earliest in cycle 698.

## Structure
- Package core_seq_pkg holds:
  - the state enum (IDLE, WLOAD, WGAP, XFEED, DRAIN, RELU, ROUT, DONE);
  - INST_IDLE=2'b00, INST_WLOAD=2'b01, INST_XFEED=2'b10.
- Sub-module seq_phase_cnt: a loadable down-counter with clear, enable (=!stall) and a terminal-count flag. It is reused for every phase length.
- Counter widths: $clog2 of the largest phase length. kij is 4 bits.

## Test plan
- Reset then start, no stall:
  - inst_w=01 in cycles 1..8 with A=1024..1031;
  - inst_w=10 in cycles 10..45 with A=0..35;
  - readout_start in cycle 696; done in cycle 697.
- kij=3 weight phase: A_xmem=1048..1055 and kij=3 throughout that iteration's WLOAD..DRAIN.
- stall high 5 cycles starting at XFEED t=10:
  - outputs inst_w=00, CEN=1, A holds 10;
  - resume at A=10, then 11;
  - done shifts to cycle 702.
- start pulsed in cycle 300 while busy: no effect, done still in cycle 697. start with stall=1 in IDLE: busy stays 0.
- reset asserted in cycle 400 (mid-XFEED): all outputs reach reset values before the next edge. A fresh start replays from kij=0, A=1024.
- Protocol check over a full pass:
  - WEN_xmem never 0;
  - CEN=0 exactly when inst_w≠00;
  - exactly 72 weight reads and 324 activation reads.
